// File: rtl/nmea_rmc_uart_tx.sv
// $GNRMC sentence generator: latches BCD fields on start and sends them over UART 8N1, LSB first.
// Define NMEA_CRLF_EN to append <cr><lf> after the checksum (61 characters instead of 59).
module nmea_rmc_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] utc,
  input  logic [31:0] lat,
  input  logic [35:0] lon,
  input  logic [23:0] date,
  input  logic        fix,
  input  logic        ns,
  input  logic        ew,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
`ifdef NMEA_CRLF_EN
  localparam int NCHAR = 61;
`else
  localparam int NCHAR = 59;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [5:0]    idx_q, idx_d, nxt_idx;
  logic [7:0]    shreg_q, shreg_d, csum_q, csum_d, ch_sel;
  logic          tx_q, tx_d, done_q, done_d, bit_end;
  logic [23:0]   utc_q, date_q;
  logic [31:0]   lat_q;
  logic [35:0]   lon_q;
  logic          fix_q, ns_q, ew_q;

  function automatic logic [7:0] dig(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h30;
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character for the index about to start; digit position is derived from the index.
  always_comb begin
    int i;
    i      = int'(nxt_idx);
    ch_sel = ",";
    case (nxt_idx) inside
      6'd0:         ch_sel = "$";
      6'd1:         ch_sel = "G";
      6'd2:         ch_sel = "N";
      6'd3:         ch_sel = "R";
      6'd4:         ch_sel = "M";
      6'd5:         ch_sel = "C";
      [6'd7:6'd12]: ch_sel = dig(4'(utc_q >> (4 * (12 - i))));
      6'd13, 6'd23, 6'd36: ch_sel = ".";
      6'd14, 6'd15: ch_sel = "0";
      6'd17:        ch_sel = fix_q ? "A" : "V";
      [6'd19:6'd22]: ch_sel = dig(4'(lat_q >> (4 * (26 - i))));
      [6'd24:6'd27]: ch_sel = dig(4'(lat_q >> (4 * (27 - i))));
      6'd29:        ch_sel = ns_q ? "S" : "N";
      [6'd31:6'd35]: ch_sel = dig(4'(lon_q >> (4 * (39 - i))));
      [6'd37:6'd40]: ch_sel = dig(4'(lon_q >> (4 * (40 - i))));
      6'd42:        ch_sel = ew_q ? "W" : "E";
      [6'd46:6'd51]: ch_sel = dig(4'(date_q >> (4 * (51 - i))));
      6'd55:        ch_sel = fix_q ? "A" : "N";
      6'd56:        ch_sel = "*";
      6'd57:        ch_sel = hexc(csum_q[7:4]);
      6'd58:        ch_sel = hexc(csum_q[3:0]);
      6'd59:        ch_sel = 8'h0D;
      6'd60:        ch_sel = 8'h0A;
      default:      ch_sel = ",";
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    csum_d  = csum_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    nxt_idx = (state_q == S_IDLE) ? '0 : idx_q + 6'd1;
    bit_end = (cnt_q == CW'(BAUD_CNT - 1));
    if (state_q != S_IDLE && !bit_end) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          csum_d  = '0;
          shreg_d = ch_sel;
          tx_d    = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = shreg_q[0];
      end
      S_DATA: if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          shreg_d = shreg_q >> 1;
          tx_d    = shreg_q[1];
        end
      end
      S_STOP: if (bit_end) begin
        cnt_d = '0;
        if (idx_q == 6'(NCHAR - 1)) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = S_START;
          idx_d   = nxt_idx;
          shreg_d = ch_sel;
          tx_d    = 1'b0;
          if (nxt_idx >= 6'd1 && nxt_idx <= 6'd55) csum_d = csum_q ^ ch_sel;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      csum_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      utc_q   <= '0;
      lat_q   <= '0;
      lon_q   <= '0;
      date_q  <= '0;
      fix_q   <= 1'b0;
      ns_q    <= 1'b0;
      ew_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      csum_q  <= csum_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      if (state_q == S_IDLE && start) begin
        utc_q  <= utc;
        lat_q  <= lat;
        lon_q  <= lon;
        date_q <= date;
        fix_q  <= fix;
        ns_q   <= ns;
        ew_q   <= ew;
      end
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_nmea_rmc_uart_tx.sv
// Bench for nmea_rmc_uart_tx: cycle-level line model built from the sentence text, plus UART decode.
module tb_nmea_rmc_uart_tx;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int BC       = 10;
`ifdef NMEA_CRLF_EN
  localparam int NCH     = 61;
  localparam int BUSYLEN = 6100;
`else
  localparam int NCH     = 59;
  localparam int BUSYLEN = 5900;
`endif
  localparam int SLEN = NCH * 10 * BC;

  logic clk, rst_n, start, fix, ns, ew, tx, busy, done;
  logic [23:0] utc, date;
  logic [31:0] lat;
  logic [35:0] lon;

  nmea_rmc_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .utc(utc), .lat(lat), .lon(lon),
    .date(date), .fix(fix), .ns(ns), .ew(ew), .tx(tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  string crlf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic check_s(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got [%s] expected [%s]", name, act, req);
    end
  endtask

  function automatic string dig(input logic [35:0] v, input int n);
    string s;
    logic [3:0] d;
    s = "";
    for (int i = n - 1; i >= 0; i--) begin
      d = v[4*i +: 4];
      s = $sformatf("%s%c", s, (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h30);
    end
    return s;
  endfunction

  function automatic string hx(input logic [3:0] n);
    return $sformatf("%c", (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
  endfunction

  function automatic string with_cs(input string p);
    logic [7:0] cs;
    cs = '0;
    for (int i = 1; i < p.len(); i++) cs ^= p[i];
    return $sformatf("%s*%s%s%s", p, hx(cs[7:4]), hx(cs[3:0]), crlf);
  endfunction

  function automatic string sentence(input logic [23:0] u, input logic [31:0] la,
                                     input logic [35:0] lo, input logic [23:0] da,
                                     input logic f, input logic s_n, input logic e_w);
    string p;
    p = $sformatf("$GNRMC,%s.00,%s,%s.%s,%s,%s.%s,%s,,,%s,,,%s",
                  dig(36'(u), 6), f ? "A" : "V", dig(36'(la[31:16]), 4), dig(36'(la[15:0]), 4),
                  s_n ? "S" : "N", dig(36'(lo[35:16]), 5), dig(36'(lo[15:0]), 4),
                  e_w ? "W" : "E", dig(36'(da), 6), f ? "A" : "N");
    return with_cs(p);
  endfunction

  // Reference: line state as a function of cycles since acceptance and the sentence text.
  string m_s;
  bit    m_busy, m_done, cmp_en;
  int    m_k, done_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_k++;
        if (m_k == SLEN) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_s    = sentence(utc, lat, lon, date, fix, ns, ew);
      end
    end
  end

  function automatic logic exp_tx();
    int c, b;
    logic [7:0] ch;
    if (!m_busy) return 1'b1;
    c  = m_k / (10 * BC);
    b  = (m_k / BC) % 10;
    ch = m_s[c];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle{tx,busy,done}", {61'b0, tx, busy, done}, {61'b0, exp_tx(), m_busy, m_done});
      if (done === 1'b1) done_cnt++;
    end
  end

  // UART decoder sampling mid-bit on the falling clock edge.
  string rx;
  bit    d_act;
  int    d_cnt;
  logic [7:0] d_byte;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_act = 1'b0;
      d_cnt = 0;
    end else if (clk == 1'b0) begin
      if (!d_act) begin
        if (tx == 1'b0) begin
          d_act = 1'b1;
          d_cnt = 1;
        end
      end else begin
        d_cnt++;
        if (d_cnt >= 15 && d_cnt <= 85 && (d_cnt % 10) == 5) d_byte[d_cnt/10 - 1] = tx;
        if (d_cnt == 95) begin
          rx    = $sformatf("%s%c", rx, d_byte);
          d_act = 1'b0;
        end
      end
    end
  end

  task automatic wait_end(output int n);
    n = 0;
    while (busy === 1'b1 && n < SLEN + 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_sentence(output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(n);
    check("done_at_end", {63'b0, done}, 64'd1);
  endtask

  task automatic rand_fields();
    utc  = 24'($urandom);
    lat  = 32'($urandom);
    lon  = {4'($urandom_range(0, 15)), 32'($urandom)};
    date = 24'($urandom);
    fix  = 1'($urandom);
    ns   = 1'($urandom);
    ew   = 1'($urandom);
  endtask

  string lit1, lit3, r1, exp2;
  int n, d0;

  initial begin
`ifdef NMEA_CRLF_EN
    crlf = "\r\n";
`else
    crlf = "";
`endif
    rst_n = 1'b0; start = 1'b0; rx = "";
    utc = '0; lat = '0; lon = '0; date = '0; fix = 1'b0; ns = 1'b0; ew = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_tx", {63'b0, tx}, 64'd1);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    lit1 = $sformatf("$GNRMC,000000.00,V,0000.0000,N,00000.0000,E,,,000000,,,N*58%s", crlf);
    lit3 = with_cs("$GNRMC,113232.00,A,3449.2918,N,11333.6260,E,,,140421,,,A");

    // All-zero fields
    rx = ""; d0 = done_cnt;
    run_sentence(n);
    check_s("zero_sentence", rx, lit1);
    check("zero_busy_len", 64'(n), 64'(BUSYLEN));
    @(negedge clk);
    check("zero_done_count", 64'(done_cnt - d0), 64'd1);

    // Typical fix
    utc = 24'h113232; lat = 32'h34492918; lon = 36'h113336260; date = 24'h140421;
    fix = 1'b1; ns = 1'b0; ew = 1'b0;
    rx = "";
    run_sentence(n);
    check_s("fix_sentence", rx, lit3);
    check("fix_busy_len", 64'(n), 64'(BUSYLEN));

    // Non-decimal nibble renders as '0'
    utc = 24'hA00000; lat = '0; lon = '0; date = '0; fix = 1'b0;
    rx = "";
    run_sentence(n);
    check_s("hex_nibble_sentence", rx, lit1);

    // Ignored mid-sentence start, field changes after latch, start held through done
    utc = 24'h113232; lat = 32'h34492918; lon = 36'h113336260; date = 24'h140421;
    fix = 1'b1; ns = 1'b0; ew = 1'b0;
    rx = "";
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_fields();
    exp2 = sentence(utc, lat, lon, date, fix, ns, ew);
    repeat (SLEN - 1010) @(negedge clk);
    start = 1'b1;
    wait_end(n);
    check("held_done", {63'b0, done}, 64'd1);
    r1 = rx; rx = "";
    @(negedge clk);
    check("restart_tx_low", {63'b0, tx}, 64'd0);
    check("restart_busy", {63'b0, busy}, 64'd1);
    start = 1'b0;
    check_s("first_of_pair", r1, lit3);
    wait_end(n);
    check_s("second_of_pair", rx, exp2);

    // Random fields
    for (int t = 0; t < 2; t++) begin
      rand_fields();
      exp2 = sentence(utc, lat, lon, date, fix, ns, ew);
      @(negedge clk);
      rx = "";
      run_sentence(n);
      check_s("random_sentence", rx, exp2);
      check("random_busy_len", 64'(n), 64'(BUSYLEN));
    end

    // Asynchronous reset during data bits of character 20
    rand_fields();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20 * 10 * BC + 35) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {63'b0, tx}, 64'd1);
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    check("async_rst_done", {63'b0, done}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rand_fields();
    exp2 = sentence(utc, lat, lon, date, fix, ns, ew);
    rx = "";
    run_sentence(n);
    check_s("post_reset_sentence", rx, exp2);
    check("post_reset_busy_len", 64'(n), 64'(BUSYLEN));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nmea_rmc_uart_tx.md
Name: nmea_rmc_uart_tx

Overview:
- GPS-side emulator that builds one fixed-format $GNRMC sentence from latched BCD fields.
- Computes the NMEA XOR checksum and serialises the sentence on a UART 8N1 line, LSB first.
- Feeds the GPS/UART receive path during board bring-up and loopback, in place of a physical GPS module.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 9600, line rate in bit/s; BAUD_CNT = CLK_FREQ/BAUD, integer division (5208 at defaults) clock cycles per bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request one sentence; sampled only while busy=0.
- utc  input  24  BCD hhmmss, hh in [23:16].
- lat  input  32  BCD ddmmmmmm, rendered ddmm.mmmm.
- lon  input  36  BCD dddmmmmmm, rendered dddmm.mmmm.
- date  input  24  BCD ddmmyy.
- fix  input  1  1 gives status 'A' and mode 'A'; 0 gives status 'V' and mode 'N'.
- ns  input  1  0 gives 'N', 1 gives 'S'.
- ew  input  1  0 gives 'E', 1 gives 'W'.
- tx  output  1  UART line, idles high.
- busy  output  1  high while a sentence is in flight.
- done  output  1  one-cycle pulse at end of sentence.

Behaviour:
- Reset (async, any time, including mid-bit): tx=1, busy=0, done=0, all counters and checksum cleared. No partial character resumes after reset.
- Sentence format, with <cr><lf> present only when the optional feature is enabled:
  $GNRMC,hhmmss.00,S,ddmm.mmmm,H,dddmm.mmmm,H,,,ddmmyy,,,M*XX<cr><lf>
  - 61 characters with the feature, 59 without.
  - Speed, course and magnetic-variation fields are always empty.
- Digit mapping: nibble 0-9 maps to 0x30+nibble. Nibble A-F is emitted as '0' (0x30), silently.
- Checksum:
  - 8-bit XOR over every character strictly between '$' and '*' (55 characters).
  - Emitted as two uppercase hex ASCII characters, high nibble first.
- Start handshake:
  - start=1 at a clock edge with busy=0 latches all field inputs.
  - busy=1 and tx=0 (start bit of '$') take effect at that same edge.
  - Field input changes after the latch have no effect on the sentence.
- While busy=1, start is ignored; no queueing.
- FSM states:
  - IDLE: on start go to LOAD.
  - LOAD/START: drive the start bit.
  - DATA: 8 bits, LSB first.
  - STOP: drive the stop bit.
  - After STOP, go to NEXT_CHAR or FINISH.
- Bit timing: each bit is held exactly BAUD_CNT cycles. Characters are sent back to back with no extra idle bits.
- Character index counter selects the source character each time a new character begins. Checksum accumulation happens at character selection, and the hex characters use the final accumulated value.
- Completion: after the last stop bit's BAUD_CNT cycles, busy falls and done=1 for exactly one cycle, in the same cycle.
  - A start sampled in that done cycle is accepted, because busy=0.
  - The next start bit then follows immediately.
- Total busy duration = Nchar*10*BAUD_CNT cycles.

Optional Feature:
- Macro NMEA_CRLF_EN.
- Defined: <cr><lf> (0x0D, 0x0A) is appended after the checksum; Nchar=61.
- Undefined: the sentence ends after the second checksum character; Nchar=59. The FSM goes from the last checksum character straight to FINISH.
- Checksum value is identical either way.

Test Plan:
- All fields zero, fix=0, ns=0, ew=0, NMEA_CRLF_EN defined → bench UART decode yields exactly "$GNRMC,000000.00,V,0000.0000,N,00000.0000,E,,,000000,,,N*58\r\n". done pulses once; busy high for 61*10*BAUD_CNT cycles.
- CLK_FREQ=1000, BAUD=100 (BAUD_CNT=10) → every tx bit lasts exactly 10 cycles; busy lasts exactly 6100 cycles, 5900 with NMEA_CRLF_EN undefined.
- utc=0x113232, lat=0x34492918, lon=0x113336260, date=0x140421, fix=1, ns=0, ew=0 → decode gives "$GNRMC,113232.00,A,3449.2918,N,11333.6260,E,,,140421,,,A*XX". XX equals the bench-computed XOR of characters 1..55.
- utc=0xA00000, all other fields zero, fix=0 → the hh field decodes as "00"; the sentence and checksum "*58" are identical to the first scenario.
- start pulsed again at cycle 1000 while busy; then start held high through the done cycle → the mid-sentence start is ignored. A second sentence begins with its start bit on the cycle after done.
- rst_n asserted mid-DATA of character 20 → tx=1 and busy=0 immediately (asynchronously). After release, a new start produces a complete, correct sentence.
